intmul_sched: RTL and testbench
===============================

# intmul_sched

Round-robin scheduler that shares the single integer multiplier and its 16-entry result buffer among four thread requesters. It arbitrates requests, allocates a result slot per grant (result address = {thread, slot}), latches operands and sign-extend controls into the multiplier issue registers, and drives the multiplier write strobe. It also keeps a per-slot reserved/done scoreboard so consumers know when a product is readable. It sits between the thread issue logic and the integer multiplier.

## Interface
- NUM_REQ, 4: number of requesters; fixed at 4, with a 2-bit thread field.
- SLOTS, 4: result slots per requester; fixed at 4, with a 2-bit slot field.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- req  in  4  per-thread multiply request.
- req_oprndA, req_oprndB  in  128 each  operands; thread i uses bits [32i+31:32i].
- req_sextA, req_sextB  in  4 each  per-thread sign-extend controls for A and B.
- flush  in  4  per-thread scoreboard clear.
- rel_en  in  1  release strobe for a consumed slot.
- rel_addrs  in  4  slot released, as {thread, slot}.
- mul_ready  in  1  ready output of the multiplier.
- gnt  out  4  one-hot grant pulse.
- gnt_slot  out  2  slot allocated to the granted thread.
- mul_wren  out  1  multiplier write strobe.
- mul_wraddrs  out  4  result address, {thread, slot}.
- mul_oprndA, mul_oprndB  out  32 each  latched operands.
- mul_sextA, mul_sextB  out  1 each  latched sign-extend controls.
- slot_rsv  out  16  slot reserved (allocated and not yet released).
- slot_done  out  16  product written and readable.
- busy  out  1  1 when any slot_rsv bit is set or mul_wren is 1.

## Operation
- FSM states:
  - IDLE: mul_wren=0.
  - ISSUE: mul_wren=1 for exactly one cycle per grant.
  - FSM enters ISSUE at any edge where a grant occurs, and returns to IDLE otherwise. Back-to-back ISSUE is allowed.
- Free slot: slot s of thread i is free when slot_rsv[{i,s}]=0. The allocator picks the lowest-index free slot.
- Eligibility: thread i is eligible when req[i]=1, flush[i]=0, and at least one of its slots is free.
- Arbitration occurs each cycle in which mul_ready=1. With mul_ready=0 there is no grant, and no state changes except release/flush/done.
- Round-robin pointer rr (2 bits):
  - The first eligible thread at or after rr is granted.
  - After a grant to thread i, rr = i+1 mod 4.
  - rr is unchanged when there is no grant.
- On a grant edge (end of cycle t):
  - Capture the granted thread's operands and sign-extend controls into the mul_* registers.
  - mul_wraddrs = {i, slot}; mul_wren=1.
  - gnt[i]=1 and gnt_slot=slot, for one cycle.
  - Set slot_rsv[{i,slot}].
- Done: at the edge ending a cycle with mul_wren=1, set slot_done[mul_wraddrs]. The multiplier RAM writes on that same edge.
- Release: on rel_en=1, clear both slot_rsv and slot_done for rel_addrs.
  - Releasing an unreserved slot is ignored.
  - A released slot becomes free only in the following cycle; same-cycle reuse is not allowed.
- Flush: flush[i]=1 clears all 4 rsv and done bits of thread i at the edge.
  - An in-flight mul_wren for thread i still writes the RAM but does not set done.
  - No grant to thread i in that cycle.
- Priority on a single slot bit within one edge: flush > release > set (grant/done).
- Requester protocol:
  - gnt is observed in cycle t+1.
  - req still high in cycle t+1 counts as a new request; drop req in t+1 if no further work.
  - Operands only need to be valid in the cycle req is sampled.

## Timing
- Reset values:
  - gnt=0, gnt_slot=0, mul_wren=0, mul_wraddrs=0.
  - mul_oprndA=mul_oprndB=0, mul_sextA=mul_sextB=0.
  - slot_rsv=0, slot_done=0, busy=0.
  - rr=0, FSM=IDLE.
- Grant latency: req sampled in cycle t gives gnt and mul_wren in t+1, and slot_done in t+2.
- Throughput: one grant per cycle while mul_ready=1.
- All outputs are registered; no combinational path from req to any output.
- Reset asserted mid-operation clears everything immediately, including an in-progress ISSUE.

## Test plan
- Reset, then req=4'b0001 with A=7, B=6, sext=0:
  - gnt=0001 and gnt_slot=0 one cycle later, with mul_wraddrs=0, mul_oprndA=7, mul_oprndB=6.
  - slot_done[0]=1 the cycle after that.
- All four req held high for 8 cycles, mul_ready=1: grant order 0,1,2,3,0,1,2,3; each thread holds slots 0 and 1 reserved.
- Thread 2 holds req with no releases: 4 grants using slots 0-3 (addrs 8-11), then no grant while other threads still rotate.
  - Release addr 9: thread 2 is granted slot 1 two cycles after rel_en.
- mul_ready=0 for 3 cycles with req=1111: no gnt and no mul_wren; rr is unchanged and arbitration resumes at the same thread.
- Flush[1] in the same cycle as a grant decision where thread 1 is first eligible: thread 2 is granted instead, and bits 4-7 of slot_rsv/slot_done read 0.
- RESET low one cycle after a grant: all outputs read 0 immediately; after RESET goes high, the first grant goes to thread 0.

Source files
------------

// File: rtl/intmul_sched.sv
// rtl/intmul_sched.sv - round-robin scheduler for the shared integer multiplier and its result buffer
module intmul_sched #(
    parameter int NUM_REQ = 4,
    parameter int SLOTS   = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*32-1:0]     req_oprndA,
    input  logic [NUM_REQ*32-1:0]     req_oprndB,
    input  logic [NUM_REQ-1:0]        req_sextA,
    input  logic [NUM_REQ-1:0]        req_sextB,
    input  logic [NUM_REQ-1:0]        flush,
    input  logic                      rel_en,
    input  logic [3:0]                rel_addrs,
    input  logic                      mul_ready,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [1:0]                gnt_slot,
    output logic                      mul_wren,
    output logic [3:0]                mul_wraddrs,
    output logic [31:0]               mul_oprndA,
    output logic [31:0]               mul_oprndB,
    output logic                      mul_sextA,
    output logic                      mul_sextB,
    output logic [NUM_REQ*SLOTS-1:0]  slot_rsv,
    output logic [NUM_REQ*SLOTS-1:0]  slot_done,
    output logic                      busy
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;
    localparam int NSLOT = NUM_REQ * SLOTS;

    logic [0:0]         state;
    logic [1:0]         rr;
    logic [NUM_REQ-1:0] eligible;
    logic               grantValid;
    logic [1:0]         grantThread;
    logic [1:0]         grantSlot;
    logic [1:0]         cand;
    logic               slotFound;
    logic [NSLOT-1:0]   rsvNext;
    logic [NSLOT-1:0]   doneNext;

    // The write strobe is exactly the ISSUE state, so it is a registered output.
    assign mul_wren = (state == ISSUE);

    // Eligibility, round-robin pick, lowest free slot and next scoreboard contents.
    always_comb begin
        eligible    = '0;
        grantValid  = 1'b0;
        grantThread = rr;
        grantSlot   = 2'd0;
        slotFound   = 1'b0;
        cand        = 2'd0;
        rsvNext     = slot_rsv;
        doneNext    = slot_done;

        // A slot released this cycle still reads reserved here, so it cannot be reused until next cycle.
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req[i] & ~flush[i] & ~(&slot_rsv[SLOTS*i +: SLOTS]);
        end

        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr + 2'(k);
            if (!grantValid && mul_ready && eligible[cand]) begin
                grantValid  = 1'b1;
                grantThread = cand;
            end
        end

        for (int s = 0; s < SLOTS; s++) begin
            if (!slotFound && !slot_rsv[{grantThread, 2'(s)}]) begin
                slotFound = 1'b1;
                grantSlot = 2'(s);
            end
        end

        // Sets first, then release, then flush, so later clears win on the same bit.
        if (grantValid) begin
            rsvNext[{grantThread, grantSlot}] = 1'b1;
        end
        if (mul_wren) begin
            doneNext[mul_wraddrs] = 1'b1;
        end
        if (rel_en) begin
            rsvNext[rel_addrs]  = 1'b0;
            doneNext[rel_addrs] = 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (flush[i]) begin
                rsvNext[SLOTS*i +: SLOTS]  = '0;
                doneNext[SLOTS*i +: SLOTS] = '0;
            end
        end
    end

    // FSM and round-robin pointer: ISSUE follows every grant edge, pointer moves past the winner.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            rr    <= 2'd0;
        end else begin
            state <= grantValid ? ISSUE : IDLE;
            if (grantValid) begin
                rr <= grantThread + 2'd1;
            end
        end
    end

    // Grant pulse and multiplier issue registers; address and operands hold between grants.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            gnt         <= '0;
            gnt_slot    <= 2'd0;
            mul_wraddrs <= 4'd0;
            mul_oprndA  <= 32'd0;
            mul_oprndB  <= 32'd0;
            mul_sextA   <= 1'b0;
            mul_sextB   <= 1'b0;
        end else begin
            gnt <= '0;
            if (grantValid) begin
                gnt[grantThread] <= 1'b1;
                gnt_slot         <= grantSlot;
                mul_wraddrs      <= {grantThread, grantSlot};
                mul_oprndA       <= req_oprndA[32*grantThread +: 32];
                mul_oprndB       <= req_oprndB[32*grantThread +: 32];
                mul_sextA        <= req_sextA[grantThread];
                mul_sextB        <= req_sextB[grantThread];
            end
        end
    end

    // Reserved/done scoreboard and busy flag, all taken from the next-state values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            slot_rsv  <= '0;
            slot_done <= '0;
            busy      <= 1'b0;
        end else begin
            slot_rsv  <= rsvNext;
            slot_done <= doneNext;
            busy      <= (|rsvNext) | grantValid;
        end
    end
endmodule

// File: tb/tb_intmul_sched.sv
// tb/tb_intmul_sched.sv - randomized and directed bench for intmul_sched
module tb_intmul_sched;
    logic         CLK = 1'b0;
    logic         RESET;
    logic [3:0]   req;
    logic [127:0] req_oprndA, req_oprndB;
    logic [3:0]   req_sextA, req_sextB, flush;
    logic         rel_en;
    logic [3:0]   rel_addrs;
    logic         mul_ready;
    logic [3:0]   gnt;
    logic [1:0]   gnt_slot;
    logic         mul_wren;
    logic [3:0]   mul_wraddrs;
    logic [31:0]  mul_oprndA, mul_oprndB;
    logic         mul_sextA, mul_sextB;
    logic [15:0]  slot_rsv, slot_done;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    intmul_sched dut (
        .CLK(CLK), .RESET(RESET), .req(req), .req_oprndA(req_oprndA), .req_oprndB(req_oprndB),
        .req_sextA(req_sextA), .req_sextB(req_sextB), .flush(flush), .rel_en(rel_en),
        .rel_addrs(rel_addrs), .mul_ready(mul_ready), .gnt(gnt), .gnt_slot(gnt_slot),
        .mul_wren(mul_wren), .mul_wraddrs(mul_wraddrs), .mul_oprndA(mul_oprndA),
        .mul_oprndB(mul_oprndB), .mul_sextA(mul_sextA), .mul_sextB(mul_sextB),
        .slot_rsv(slot_rsv), .slot_done(slot_done), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // reference model: scoreboard as bit arrays, pending issue described by thread/slot numbers
    bit          m_rsv[16];
    bit          m_done[16];
    int          m_rr;
    bit          m_wren;
    int          m_waddr;
    int          m_gt;
    int          m_gslot;
    logic [31:0] m_A, m_B;
    bit          m_sA, m_sB;

    function automatic logic [15:0] pack(input bit a[16]);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = a[i];
        return r;
    endfunction

    function automatic int free_slot(input int t);
        for (int s = 0; s < 4; s++) if (!m_rsv[4*t+s]) return s;
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt();
        logic [3:0] v;
        v = 4'd0;
        if (m_gt >= 0) v[m_gt] = 1'b1;
        return v;
    endfunction

    function automatic bit exp_busy();
        bit b;
        b = m_wren;
        for (int i = 0; i < 16; i++) b = b | m_rsv[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin m_rsv[i] = 0; m_done[i] = 0; end
        m_rr = 0; m_wren = 0; m_waddr = 0; m_gt = -1; m_gslot = 0;
        m_A = 0; m_B = 0; m_sA = 0; m_sB = 0;
    endtask

    task automatic model_step();
        int g;
        int s;
        bit nr[16];
        bit nd[16];
        g = -1;
        s = -1;
        nr = m_rsv;
        nd = m_done;
        if (mul_ready) begin
            for (int k = 0; k < 4; k++) begin
                int t;
                t = (m_rr + k) % 4;
                if (g < 0 && req[t] && !flush[t] && free_slot(t) >= 0) g = t;
            end
        end
        if (g >= 0) begin s = free_slot(g); nr[4*g+s] = 1; end
        if (m_wren) nd[m_waddr] = 1;
        if (rel_en) begin nr[rel_addrs] = 0; nd[rel_addrs] = 0; end
        for (int t = 0; t < 4; t++) begin
            if (flush[t]) for (int q = 0; q < 4; q++) begin nr[4*t+q] = 0; nd[4*t+q] = 0; end
        end
        m_rsv  = nr;
        m_done = nd;
        m_gt   = g;
        m_wren = (g >= 0);
        if (g >= 0) begin
            m_gslot = s;
            m_waddr = 4*g + s;
            m_A  = req_oprndA[32*g +: 32];
            m_B  = req_oprndB[32*g +: 32];
            m_sA = req_sextA[g];
            m_sB = req_sextB[g];
            m_rr = (g + 1) % 4;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        req = 0; flush = 0; rel_en = 0; rel_addrs = 0; mul_ready = 1;
        req_oprndA = 0; req_oprndB = 0; req_sextA = 0; req_sextB = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (gnt !== 4'd0 || mul_wren !== 1'b0) begin n_fail++; $display("FAIL reset_gnt_wren: got gnt=%b wren=%b expected 0000/0", gnt, mul_wren); end
        n_tests++; if (slot_rsv !== 16'd0 || slot_done !== 16'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_scoreboard: got rsv=%h done=%h busy=%b expected 0", slot_rsv, slot_done, busy); end
        n_tests++; if (mul_wraddrs !== 4'd0 || mul_oprndA !== 32'd0 || mul_oprndB !== 32'd0 || gnt_slot !== 2'd0 || mul_sextA !== 1'b0 || mul_sextB !== 1'b0) begin n_fail++; $display("FAIL reset_issue_regs: got addr=%h A=%h B=%h slot=%0d expected 0", mul_wraddrs, mul_oprndA, mul_oprndB, gnt_slot); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001; req_oprndA[31:0] = 32'd7; req_oprndB[31:0] = 32'd6;
        tick();
        req = 4'b0000;
        n_tests++; if (gnt !== 4'b0001 || gnt_slot !== 2'd0 || mul_wren !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got gnt=%b slot=%0d wren=%b expected 0001/0/1", gnt, gnt_slot, mul_wren); end
        n_tests++; if (mul_wraddrs !== 4'd0 || mul_oprndA !== 32'd7 || mul_oprndB !== 32'd6) begin n_fail++; $display("FAIL single_operands: got addr=%0d A=%0d B=%0d expected 0/7/6", mul_wraddrs, mul_oprndA, mul_oprndB); end
        n_tests++; if (slot_done[0] !== 1'b0 || slot_rsv[0] !== 1'b1) begin n_fail++; $display("FAIL single_pre_done: got done0=%b rsv0=%b expected 0/1", slot_done[0], slot_rsv[0]); end
        tick();
        n_tests++; if (slot_done[0] !== 1'b1 || mul_wren !== 1'b0 || gnt !== 4'd0) begin n_fail++; $display("FAIL single_done: got done0=%b wren=%b gnt=%b expected 1/0/0000", slot_done[0], mul_wren, gnt); end
        rel_en = 1; rel_addrs = 4'd0;
        tick();
        rel_en = 0;
        n_tests++; if (slot_rsv !== 16'd0 || slot_done !== 16'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_release: got rsv=%h done=%h busy=%b expected 0/0/0", slot_rsv, slot_done, busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] e;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            req_oprndA = {$urandom, $urandom, $urandom, $urandom};
            tick();
            e = 4'd0; e[k % 4] = 1'b1;
            n_tests++; if (gnt !== e) begin n_fail++; $display("FAIL rr_order[%0d]: got %b expected %b", k, gnt, e); end
        end
        req = 4'b0000;
        tick();
        n_tests++; if (slot_rsv !== 16'h3333 || slot_done !== 16'h3333 || busy !== 1'b1) begin n_fail++; $display("FAIL rr_slots: got rsv=%h done=%h busy=%b expected 3333/3333/1", slot_rsv, slot_done, busy); end
    endtask

    task automatic test_slot_exhaust();
        logic [3:0] e;
        do_reset();
        req = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++; if (gnt !== 4'b0100 || gnt_slot !== 2'(k) || mul_wraddrs !== 4'(8 + k)) begin n_fail++; $display("FAIL exhaust_fill[%0d]: got gnt=%b slot=%0d addr=%0d expected 0100/%0d/%0d", k, gnt, gnt_slot, mul_wraddrs, k, 8 + k); end
        end
        req = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            tick();
            e = 4'd0; e[(3 + k) % 4] = 1'b1;
            n_tests++; if (gnt !== e) begin n_fail++; $display("FAIL exhaust_others[%0d]: got %b expected %b", k, gnt, e); end
        end
        req = 4'b0100; rel_en = 1; rel_addrs = 4'd9;
        tick();
        rel_en = 0;
        n_tests++; if (gnt !== 4'd0 || slot_rsv[11:8] !== 4'b1101) begin n_fail++; $display("FAIL exhaust_release_cycle: got gnt=%b rsv2=%b expected 0000/1101", gnt, slot_rsv[11:8]); end
        tick();
        req = 4'b0000;
        n_tests++; if (gnt !== 4'b0100 || gnt_slot !== 2'd1 || mul_wraddrs !== 4'd9) begin n_fail++; $display("FAIL exhaust_regrant: got gnt=%b slot=%0d addr=%0d expected 0100/1/9", gnt, gnt_slot, mul_wraddrs); end
    endtask

    task automatic test_ready_stall();
        do_reset();
        req = 4'b1111;
        tick();
        tick();
        mul_ready = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (gnt !== 4'd0 || mul_wren !== 1'b0) begin n_fail++; $display("FAIL stall[%0d]: got gnt=%b wren=%b expected 0000/0", k, gnt, mul_wren); end
        end
        mul_ready = 1;
        tick();
        req = 4'b0000;
        n_tests++; if (gnt !== 4'b0100 || mul_wren !== 1'b1) begin n_fail++; $display("FAIL stall_resume: got gnt=%b wren=%b expected 0100/1", gnt, mul_wren); end
    endtask

    task automatic test_flush();
        do_reset();
        req = 4'b0010; tick();
        req = 4'b0000; tick();
        req = 4'b0001; tick();
        n_tests++; if (slot_done[4] !== 1'b1 || slot_rsv[4] !== 1'b1) begin n_fail++; $display("FAIL flush_setup: got done4=%b rsv4=%b expected 1/1", slot_done[4], slot_rsv[4]); end
        req = 4'b0110; flush = 4'b0010;
        tick();
        req = 4'b0000; flush = 4'b0000;
        n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL flush_gnt: got %b expected 0100", gnt); end
        n_tests++; if (slot_rsv[7:4] !== 4'd0 || slot_done[7:4] !== 4'd0) begin n_fail++; $display("FAIL flush_clear: got rsv=%b done=%b expected 0000/0000", slot_rsv[7:4], slot_done[7:4]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        RESET = 1'b0;
        #1;
        model_reset();
        n_tests++; if (gnt !== 4'd0 || mul_wren !== 1'b0 || slot_rsv !== 16'd0 || busy !== 1'b0 || mul_oprndA !== 32'd0) begin n_fail++; $display("FAIL reset_mid: got gnt=%b wren=%b rsv=%h busy=%b A=%h expected all 0", gnt, mul_wren, slot_rsv, busy, mul_oprndA); end
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        req = 4'b1111;
        tick();
        req = 4'b0000;
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_mid_first: got %b expected 0001", gnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req        = 4'($urandom);
            flush      = 4'(($urandom_range(0, 15) == 0) ? $urandom : 0);
            rel_en     = 1'($urandom_range(0, 1));
            rel_addrs  = 4'($urandom);
            mul_ready  = ($urandom_range(0, 4) != 0);
            req_oprndA = {$urandom, $urandom, $urandom, $urandom};
            req_oprndB = {$urandom, $urandom, $urandom, $urandom};
            req_sextA  = 4'($urandom);
            req_sextB  = 4'($urandom);
            tick();
            n_tests++; if (gnt !== exp_gnt() || mul_wren !== m_wren) begin n_fail++; $display("FAIL rand_gnt@%0d: got gnt=%b wren=%b expected %b/%b", c, gnt, mul_wren, exp_gnt(), m_wren); end
            n_tests++; if (slot_rsv !== pack(m_rsv) || slot_done !== pack(m_done) || busy !== exp_busy()) begin n_fail++; $display("FAIL rand_board@%0d: got rsv=%h done=%h busy=%b expected %h/%h/%b", c, slot_rsv, slot_done, busy, pack(m_rsv), pack(m_done), exp_busy()); end
            if (m_gt >= 0) begin
                n_tests++; if (gnt_slot !== 2'(m_gslot) || mul_wraddrs !== 4'(m_waddr) || mul_oprndA !== m_A || mul_oprndB !== m_B || mul_sextA !== m_sA || mul_sextB !== m_sB) begin n_fail++; $display("FAIL rand_issue@%0d: got slot=%0d addr=%0d A=%h B=%h sx=%b%b expected %0d/%0d/%h/%h/%b%b", c, gnt_slot, mul_wraddrs, mul_oprndA, mul_oprndB, mul_sextA, mul_sextB, m_gslot, m_waddr, m_A, m_B, m_sA, m_sB); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        RESET = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_slot_exhaust();
        test_ready_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
